vending_ctrl_param: RTL and testbench

//  Parametrised vending controller: accepts a coin deposit plus item request over a valid/ready handshake.

---
 rtl/vending_pkg.sv | 49 ++++
 rtl/vending_coin_bank.sv | 56 +++++
 rtl/vending_ctrl_param.sv | 189 ++++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller and its coin bank.
package vending_pkg;

    // Coin slots, ordered from largest to smallest so greedy change walks up the index.
    typedef enum logic [1:0] {
        Coin50 = 2'd0,
        Coin10 = 2'd1,
        Coin5  = 2'd2,
        Coin1  = 2'd3
    } coin_e;

    localparam int unsigned NumCoins = 4;

    typedef enum logic [1:0] {
        ItemNone = 2'd0,
        ItemA    = 2'd1,
        ItemB    = 2'd2,
        ItemC    = 2'd3
    } item_e;

    typedef enum logic [1:0] {
        StatOk       = 2'd0,
        StatLowFunds = 2'd1,
        StatSoldOut  = 2'd2,
        StatNoChange = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StDisp  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefaultCostA = 8;
    localparam int unsigned DefaultCostB = 15;
    localparam int unsigned DefaultCostC = 22;

    // Face value of a coin slot.
    function automatic int unsigned coin_value(input coin_e c);
        unique case (c)
            Coin50:  return 50;
            Coin10:  return 10;
            Coin5:   return 5;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/vending_coin_bank.sv
// Per-denomination coin stock: saturating deposit, single-coin payout, rollback restore.
module vending_coin_bank
    import vending_pkg::*;
#(
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned INIT_COIN = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               deposit_en,
    input  logic [NumCoins-1:0][1:0]           deposit_cnt,
    input  logic                               dec_en,
    input  coin_e                              dec_sel,
    input  logic                               restore_en,
    input  logic [NumCoins-1:0][CNT_W-1:0]     restore_cnt,
    output logic [NumCoins-1:0][CNT_W-1:0]     stock
);

    localparam logic [CNT_W:0]   MaxCnt  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] InitCnt = CNT_W'(INIT_COIN);

    logic [NumCoins-1:0][CNT_W-1:0] stock_q, stock_d;
    logic [NumCoins-1:0][CNT_W:0]   dep_sum;

    // Next stock: deposit (with saturation), restore, or one-coin decrement.
    always_comb begin
        stock_d = stock_q;
        for (int i = 0; i < NumCoins; i++) begin
            dep_sum[i] = {1'b0, stock_q[i]} + (CNT_W + 1)'(deposit_cnt[i]);
        end
        if (deposit_en) begin
            for (int i = 0; i < NumCoins; i++) begin
                // Coins beyond the counter range are simply lost.
                stock_d[i] = (dep_sum[i] > MaxCnt) ? {CNT_W{1'b1}} : dep_sum[i][CNT_W-1:0];
            end
        end else if (restore_en) begin
            for (int i = 0; i < NumCoins; i++) begin
                stock_d[i] = stock_q[i] + restore_cnt[i];
            end
        end else if (dec_en) begin
            stock_d[dec_sel] = stock_q[dec_sel] - CNT_W'(1);
        end
    end

    // Stock registers with synchronous active-low reset to the initial fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stock_q <= {NumCoins{InitCnt}};
        end else begin
            stock_q <= stock_d;
        end
    end

    assign stock = stock_q;

endmodule

// File: rtl/vending_ctrl_param.sv
// Vending controller: request handshake, price check, greedy change with rollback to refund.
module vending_ctrl_param
    import vending_pkg::*;
#(
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned INIT_COIN = 2,
    parameter int unsigned IST_W     = 3,
    parameter int unsigned INIT_ITEM = 4,
    parameter int unsigned VAL_W     = 8,
    parameter int unsigned COST_A    = DefaultCostA,
    parameter int unsigned COST_B    = DefaultCostB,
    parameter int unsigned COST_C    = DefaultCostC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       coin_in_50,
    input  logic [1:0]       coin_in_10,
    input  logic [1:0]       coin_in_5,
    input  logic [1:0]       coin_in_1,
    input  logic [1:0]       item_in,
    output logic [CNT_W-1:0] coin_out_50,
    output logic [CNT_W-1:0] coin_out_10,
    output logic [CNT_W-1:0] coin_out_5,
    output logic [CNT_W-1:0] coin_out_1,
    output logic [1:0]       item_out,
    output logic [1:0]       status,
    output logic [VAL_W-1:0] shortfall,
    output logic             done
);

    state_e                         state_q;
    coin_e                          ptr_q;
    logic [VAL_W-1:0]               input_q;
    logic [VAL_W-1:0]               rem_q;
    logic [1:0]                     req_item_q;
    logic [NumCoins-1:0][CNT_W-1:0] coin_out_q;
    logic [1:0]                     item_out_q;
    status_e                        status_q;
    logic [VAL_W-1:0]               shortfall_q;
    logic                           done_q;
    logic [IST_W-1:0]               item_stock_q [3];

    logic [NumCoins-1:0][CNT_W-1:0] coin_stock;
    logic [NumCoins-1:0][1:0]       deposit_cnt;
    logic                           accept;
    logic [VAL_W-1:0]               deposit_val;
    logic [VAL_W-1:0]               denom;
    logic [VAL_W-1:0]               req_cost;
    logic [1:0]                     item_idx;
    logic                           emit;
    logic                           at_last;
    logic                           rollback;

    function automatic logic [VAL_W-1:0] item_cost(input logic [1:0] item);
        case (item)
            ItemA:   return VAL_W'(COST_A);
            ItemB:   return VAL_W'(COST_B);
            ItemC:   return VAL_W'(COST_C);
            default: return '0;
        endcase
    endfunction

    // Handshake, deposit value and per-cycle payout decisions.
    always_comb begin
        accept      = req_valid && (state_q == StIdle) && (item_in != 2'd0);
        deposit_val = VAL_W'(50) * VAL_W'(coin_in_50) + VAL_W'(10) * VAL_W'(coin_in_10)
                    + VAL_W'(5) * VAL_W'(coin_in_5) + VAL_W'(coin_in_1);
        deposit_cnt[Coin50] = coin_in_50;
        deposit_cnt[Coin10] = coin_in_10;
        deposit_cnt[Coin5]  = coin_in_5;
        deposit_cnt[Coin1]  = coin_in_1;
        denom    = VAL_W'(coin_value(ptr_q));
        req_cost = item_cost(req_item_q);
        item_idx = req_item_q - 2'd1;
        at_last  = (ptr_q == Coin1);
        emit     = (state_q == StDisp) && (rem_q >= denom) && (coin_stock[ptr_q] != '0);
        // An OK sale whose change cannot be made is unwound into a refund.
        rollback = (state_q == StDisp) && !emit && at_last && (rem_q != '0)
                 && (status_q == StatOk);
    end

    vending_coin_bank #(
        .CNT_W     (CNT_W),
        .INIT_COIN (INIT_COIN)
    ) u_coin_bank (
        .clk         (clk),
        .reset       (reset),
        .deposit_en  (accept),
        .deposit_cnt (deposit_cnt),
        .dec_en      (emit),
        .dec_sel     (ptr_q),
        .restore_en  (rollback),
        .restore_cnt (coin_out_q),
        .stock       (coin_stock)
    );

    // Controller FSM with registered outputs and item stock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= Coin50;
            input_q     <= '0;
            rem_q       <= '0;
            req_item_q  <= '0;
            coin_out_q  <= '0;
            item_out_q  <= '0;
            status_q    <= StatOk;
            shortfall_q <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                item_stock_q[i] <= IST_W'(INIT_ITEM);
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        input_q     <= deposit_val;
                        req_item_q  <= item_in;
                        coin_out_q  <= '0;
                        item_out_q  <= '0;
                        status_q    <= StatOk;
                        shortfall_q <= '0;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    ptr_q   <= Coin50;
                    state_q <= StDisp;
                    if (item_stock_q[item_idx] == '0) begin
                        rem_q      <= input_q;
                        item_out_q <= '0;
                        status_q   <= StatSoldOut;
                    end else if (input_q < req_cost) begin
                        rem_q      <= input_q;
                        item_out_q <= '0;
                        status_q   <= StatLowFunds;
                    end else begin
                        rem_q      <= input_q - req_cost;
                        item_out_q <= req_item_q;
                        status_q   <= StatOk;
                    end
                end
                StDisp: begin
                    if (emit) begin
                        coin_out_q[ptr_q] <= coin_out_q[ptr_q] + CNT_W'(1);
                        rem_q             <= rem_q - denom;
                    end else if (!at_last) begin
                        ptr_q <= coin_e'(ptr_q + 2'd1);
                    end else if (rem_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (rollback) begin
                        coin_out_q <= '0;
                        rem_q      <= input_q;
                        item_out_q <= '0;
                        status_q   <= StatNoChange;
                        ptr_q      <= Coin50;
                    end else begin
                        // Refund stalled: only possible when saturation swallowed coins.
                        shortfall_q <= rem_q;
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (status_q == StatOk && item_out_q != 2'd0) begin
                        item_stock_q[item_idx] <= item_stock_q[item_idx] - IST_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign coin_out_50 = coin_out_q[Coin50];
    assign coin_out_10 = coin_out_q[Coin10];
    assign coin_out_5  = coin_out_q[Coin5];
    assign coin_out_1  = coin_out_q[Coin1];
    assign item_out    = item_out_q;
    assign status      = status_q;
    assign shortfall   = shortfall_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: directed scenarios plus random requests against a greedy model.
module tb_vending_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] valid = 2'b00;
    logic [1:0] cin50 = '0, cin10 = '0, cin5 = '0, cin1 = '0;
    logic [1:0] item_in = '0;

    logic       rdy [2];
    logic       done_w [2];
    logic [2:0] co [2][4];
    logic [1:0] item_o [2];
    logic [1:0] stat [2];
    logic [7:0] short_o [2];

    int checks = 0;
    int errors = 0;

    // Model state per DUT: coin stocks [50,10,5,1] and item stocks [A,B,C].
    int m_coin [2][4];
    int m_item [2][3];
    int m_rem;
    int exp_co [4];
    int exp_item, exp_status, exp_short, exp_lat, exp_inp;

    always #5 clk = ~clk;

    vending_ctrl_param #(.INIT_ITEM(4)) dut0 (
        .clk(clk), .reset(reset), .req_valid(valid[0]), .req_ready(rdy[0]),
        .coin_in_50(cin50), .coin_in_10(cin10), .coin_in_5(cin5), .coin_in_1(cin1),
        .item_in(item_in),
        .coin_out_50(co[0][0]), .coin_out_10(co[0][1]), .coin_out_5(co[0][2]),
        .coin_out_1(co[0][3]), .item_out(item_o[0]), .status(stat[0]),
        .shortfall(short_o[0]), .done(done_w[0])
    );

    vending_ctrl_param #(.INIT_ITEM(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(valid[1]), .req_ready(rdy[1]),
        .coin_in_50(cin50), .coin_in_10(cin10), .coin_in_5(cin5), .coin_in_1(cin1),
        .item_in(item_in),
        .coin_out_50(co[1][0]), .coin_out_10(co[1][1]), .coin_out_5(co[1][2]),
        .coin_out_1(co[1][3]), .item_out(item_o[1]), .status(stat[1]),
        .shortfall(short_o[1]), .done(done_w[1])
    );

    function automatic int cval(input int c);
        case (c)
            0: return 50;
            1: return 10;
            2: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int icost(input int item);
        case (item)
            1: return 8;
            2: return 15;
            3: return 22;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) m_coin[d][c] = 2;
            for (int i = 0; i < 3; i++) m_item[d][i] = (d == 0) ? 4 : 1;
        end
    endtask

    // One greedy pass over m_rem: take as many of each coin as value and stock allow.
    task automatic greedy(input int d);
        int k;
        for (int c = 0; c < 4; c++) begin
            k = m_rem / cval(c);
            if (k > m_coin[d][c]) k = m_coin[d][c];
            exp_co[c] += k;
            m_coin[d][c] -= k;
            m_rem -= k * cval(c);
            exp_lat += k + 1;
        end
    endtask

    task automatic model_txn(input int d, input int n50, input int n10, input int n5,
                             input int n1, input int item);
        int n [4];
        n = '{n50, n10, n5, n1};
        exp_inp = 0;
        for (int c = 0; c < 4; c++) begin
            exp_inp += n[c] * cval(c);
            m_coin[d][c] = (m_coin[d][c] + n[c] > 7) ? 7 : m_coin[d][c] + n[c];
            exp_co[c] = 0;
        end
        exp_short = 0;
        exp_lat   = 1;
        if (m_item[d][item-1] == 0) begin
            exp_status = 2; exp_item = 0; m_rem = exp_inp;
        end else if (exp_inp < icost(item)) begin
            exp_status = 1; exp_item = 0; m_rem = exp_inp;
        end else begin
            exp_status = 0; exp_item = item; m_rem = exp_inp - icost(item);
        end
        greedy(d);
        if (m_rem > 0 && exp_status == 0) begin
            for (int c = 0; c < 4; c++) begin
                m_coin[d][c] += exp_co[c];
                exp_co[c] = 0;
            end
            exp_status = 3; exp_item = 0; m_rem = exp_inp;
            greedy(d);
        end
        if (m_rem > 0) exp_short = m_rem;
        if (exp_status == 0) m_item[d][item-1]--;
    endtask

    task automatic check_outputs(input int d, input string tag);
        int sum;
        chk({tag, "_co50"}, 32'(co[d][0]), 32'(exp_co[0]));
        chk({tag, "_co10"}, 32'(co[d][1]), 32'(exp_co[1]));
        chk({tag, "_co5"}, 32'(co[d][2]), 32'(exp_co[2]));
        chk({tag, "_co1"}, 32'(co[d][3]), 32'(exp_co[3]));
        chk({tag, "_item"}, 32'(item_o[d]), 32'(exp_item));
        chk({tag, "_status"}, 32'(stat[d]), 32'(exp_status));
        chk({tag, "_short"}, 32'(short_o[d]), 32'(exp_short));
        sum = 0;
        for (int c = 0; c < 4; c++) sum += int'(co[d][c]) * cval(c);
        sum += icost(int'(item_o[d])) + int'(short_o[d]);
        chk({tag, "_balance"}, 32'(sum), 32'(exp_inp));
    endtask

    task automatic txn(input int d, input int n50, input int n10, input int n5, input int n1,
                       input int item, input bit hold, input string tag);
        int cyc;
        int busy_ready;
        bit got;
        model_txn(d, n50, n10, n5, n1, item);
        @(negedge clk);
        cin50 = 2'(n50); cin10 = 2'(n10); cin5 = 2'(n5); cin1 = 2'(n1);
        item_in = 2'(item);
        valid[d] = 1'b1;
        chk({tag, "_ready_idle"}, 32'(rdy[d]), 32'd1);
        @(posedge clk); #1;
        if (!hold) valid[d] = 1'b0;
        got = 1'b0; cyc = 0; busy_ready = 0;
        while (!got && cyc < 200) begin
            if (rdy[d]) busy_ready++;
            @(posedge clk); #1;
            cyc++;
            if (done_w[d]) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (!got) return;
        if (rdy[d]) busy_ready++;
        chk({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_outputs(d, tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done_w[d]), 32'd0);
        chk({tag, "_ready_back"}, 32'(rdy[d]), 32'd1);
        check_outputs(d, {tag, "_hold"});
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) chk({tag, "_co"}, 32'(co[d][c]), 32'd0);
            chk({tag, "_item"}, 32'(item_o[d]), 32'd0);
            chk({tag, "_status"}, 32'(stat[d]), 32'd0);
            chk({tag, "_short"}, 32'(short_o[d]), 32'd0);
            chk({tag, "_done"}, 32'(done_w[d]), 32'd0);
            chk({tag, "_ready"}, 32'(rdy[d]), 32'd1);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        // Change from stock of 1s, then the same change impossible -> rollback refund.
        txn(0, 0, 1, 0, 0, 1, 1'b0, "a_ok");
        chk("a_ok_two_ones", 32'(co[0][3]), 32'd2);
        txn(0, 0, 1, 0, 0, 1, 1'b0, "a_nochange");
        chk("a_nochange_ten", 32'(co[0][1]), 32'd1);
        txn(0, 0, 1, 1, 0, 3, 1'b0, "c_lowfunds");

        // Single-item stock: exact payment, then sold out with refund.
        txn(1, 0, 0, 3, 0, 2, 1'b0, "b_exact");
        txn(1, 0, 0, 3, 0, 2, 1'b0, "b_soldout");

        // Request with no item is ignored.
        @(negedge clk);
        valid[0] = 1'b1; item_in = 2'd0; cin10 = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("noitem_ready", 32'(rdy[0]), 32'd1);
            chk("noitem_done", 32'(done_w[0]), 32'd0);
        end
        @(negedge clk);
        valid[0] = 1'b0;

        // Valid held across busy cycles and back-to-back requests.
        txn(0, 1, 0, 0, 0, 2, 1'b1, "hold1");
        txn(0, 0, 2, 0, 3, 1, 1'b1, "hold2");
        @(negedge clk);
        valid[0] = 1'b0;

        // Random requests on both instances.
        for (int t = 0; t < 40; t++) begin
            txn(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), "rnd0");
        end
        for (int t = 0; t < 12; t++) begin
            txn(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), 1'b0, "rnd1");
        end
        @(negedge clk);
        valid = 2'b00;
        @(posedge clk);

        // Reset in the middle of dispensing.
        @(negedge clk);
        cin50 = 2'd3; cin10 = 2'd0; cin5 = 2'd0; cin1 = 2'd0; item_in = 2'd1;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        txn(0, 0, 1, 0, 0, 1, 1'b0, "after_reset");
        txn(0, 0, 1, 0, 0, 1, 1'b0, "after_reset_nc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
